receptor_comando: RTL and testbench
===================================

RECEPTOR_COMANDO -- requirements
Module: receptor_comando

Interface
REQ-001 Parameter CLKS_PER_BIT, default 5208, SHALL set clocks per serial bit (50 MHz / 9600 baud); legal range 16..65535.
REQ-002 Parameter CMD_PREPARAR, default 8'h50 ('P'), SHALL set the command byte that requests a brew.
REQ-003 clock  input  1  SHALL be the single system clock; all logic is on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 rx_esp  input  1  SHALL be the serial line from the ESP, asynchronous, idle high.
REQ-006 ocupado  input  1  SHALL be high while the cafeteira is mid-cycle and cannot accept a brew request.
REQ-007 preparar  output  1  SHALL be a one-cycle brew request pulse to the cafeteira.
REQ-008 dado  output  8  SHALL hold the last correctly received byte.
REQ-009 dado_valido  output  1  SHALL be a one-cycle pulse marking a new dado.
REQ-010 erro_recepcao  output  1  SHALL be a one-cycle pulse on a framing error (or parity error, see REQ-027).
REQ-011 comando_ignorado  output  1  SHALL be a one-cycle pulse when CMD_PREPARAR arrives while ocupado=1.
REQ-012 db_estado  output  4  SHALL expose the FSM state: IDLE=0, START=1, DATA=2, PARIDADE=3, STOP=4.

Function
REQ-013 rx_esp SHALL pass through a 2-flop synchronizer; all later references mean the synchronized value.
REQ-014 In IDLE, a low sample SHALL move the FSM to START and clear the bit-timer.
REQ-015 START SHALL resample at CLKS_PER_BIT/2 (integer division): if low, go to DATA; if high, treat it as a glitch and return to IDLE with no pulse.
REQ-016 DATA SHALL sample 8 bits, LSB first, one every CLKS_PER_BIT clocks after the mid-start sample, into a shift register.
REQ-017 After bit 7, the FSM SHALL go to STOP, or to PARIDADE when REQ-027 applies.
REQ-018 STOP SHALL sample CLKS_PER_BIT clocks after the previous sample, then return to IDLE in the next cycle.
REQ-019 When the stop sample is high, in the cycle after it: dado SHALL load the shift register and dado_valido SHALL pulse.
REQ-020 When the stop sample is low, in the cycle after it: erro_recepcao SHALL pulse, dado SHALL keep its value, and the FSM SHALL return to IDLE.
REQ-021 preparar SHALL pulse in the same cycle as dado_valido when the byte equals CMD_PREPARAR and ocupado=0; ocupado SHALL be sampled in that same cycle.
REQ-022 When the byte equals CMD_PREPARAR and ocupado=1, comando_ignorado SHALL pulse instead of preparar.
REQ-023 Any other valid byte SHALL produce dado_valido only.
REQ-024 preparar and comando_ignorado SHALL never both be high, and SHALL never be high without dado_valido.
REQ-025 Back-to-back frames SHALL be received: a start edge that arrives half a bit after the stop sample SHALL be detected.

Reset
REQ-026 While reset=0: FSM=IDLE, timer and bit counter=0, shift register and dado=8'h00, all pulse outputs=0, synchronizer flops=1. Reset mid-frame SHALL abort the frame with no pulse, and reception SHALL resume from the next falling edge after release.

Configuration
REQ-027 With macro RECEPTOR_PARIDADE_EN defined, the frame SHALL be 8E1: PARIDADE samples one bit after bit 7, then goes to STOP. On a parity mismatch with a good stop bit, erro_recepcao SHALL pulse and dado_valido, preparar and dado SHALL be suppressed. Without the macro, the frame SHALL be 8N1, state 3 SHALL be unreachable, and no parity logic SHALL exist.

Verification
REQ-028 CLKS_PER_BIT=16, ocupado=0, send 8'h50 8N1 -> one cycle with dado_valido=1, preparar=1, dado=8'h50.
REQ-029 Same frame with ocupado=1 -> dado_valido=1, comando_ignorado=1, preparar=0.
REQ-030 Send 8'hA5 with stop bit forced low -> erro_recepcao pulse, dado unchanged, then send 8'h3C -> dado_valido, dado=8'h3C, preparar=0.
REQ-031 rx_esp low for 4 clocks only (CLKS_PER_BIT=16) -> return to IDLE, no output pulse; assert reset=0 at mid-bit 3 of a frame -> db_estado=0, no pulse.
REQ-032 With RECEPTOR_PARIDADE_EN, send 8'h50 with odd parity bit -> erro_recepcao=1, preparar=0; with correct even parity -> preparar=1.

Source files
------------

// File: rtl/receptor_comando.sv
// Purpose : UART receiver for ESP commands; turns a CMD_PREPARAR byte into a brew request pulse.
// Latency : pulses appear one clock after the stop-bit sample (mid stop bit); ~2 clocks of rx synchronizer delay.
// Backpr. : none on the serial side; a command arriving while ocupado=1 is dropped and flagged with comando_ignorado.
//
// Ports:
//   clock            system clock, rising edge
//   reset            asynchronous, active-low
//   rx_esp           serial line from the ESP (asynchronous, idle high)
//   ocupado          cafeteira busy; checked in the same cycle as dado_valido
//   preparar         1-cycle brew request (valid CMD_PREPARAR byte while not busy)
//   dado             last correctly received byte
//   dado_valido      1-cycle pulse marking a new dado
//   erro_recepcao    1-cycle pulse on framing error (or parity error when enabled)
//   comando_ignorado 1-cycle pulse when CMD_PREPARAR arrives while ocupado=1
//   db_estado        FSM state: IDLE=0 START=1 DATA=2 PARIDADE=3 STOP=4
//
// Build option: define RECEPTOR_PARIDADE_EN for 8E1 framing (even parity);
// default build is 8N1 with no parity logic at all.

module receptor_comando #(
    parameter int         CLKS_PER_BIT = 5208,
    parameter logic [7:0] CMD_PREPARAR = 8'h50
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx_esp,
    input  logic       ocupado,
    output logic       preparar,
    output logic [7:0] dado,
    output logic       dado_valido,
    output logic       erro_recepcao,
    output logic       comando_ignorado,
    output logic [3:0] db_estado
);

    // Timer compare points: full bit period and the mid-start-bit point.
    localparam logic [15:0] LP_BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] LP_HALF_LAST = 16'((CLKS_PER_BIT / 2) - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_START    = 3'd1,
        ST_DATA     = 3'd2,
        ST_PARIDADE = 3'd3,
        ST_STOP     = 3'd4
    } estado_t;

    estado_t     r_estado;
    logic        r_rx_meta;
    logic        r_rx_sync;
    logic [15:0] r_timer;
    logic [2:0]  r_bit_cnt;
    logic [7:0]  r_shift;
    logic [7:0]  r_dado;
    logic        r_dado_valido;
    logic        r_erro;
    logic        r_cmd_match;
`ifdef RECEPTOR_PARIDADE_EN
    logic        r_par_err;
`endif

    logic w_rx;
    logic w_bit_tick;
    logic w_half_tick;

    assign w_rx        = r_rx_sync;
    assign w_bit_tick  = (r_timer == LP_BIT_LAST);
    assign w_half_tick = (r_timer == LP_HALF_LAST);

    // Two-flop synchronizer; resets to the idle (high) line level so that
    // reset release never looks like a start edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= rx_esp;
            r_rx_sync <= r_rx_meta;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado      <= ST_IDLE;
            r_timer       <= 16'd0;
            r_bit_cnt     <= 3'd0;
            r_shift       <= 8'h00;
            r_dado        <= 8'h00;
            r_dado_valido <= 1'b0;
            r_erro        <= 1'b0;
            r_cmd_match   <= 1'b0;
`ifdef RECEPTOR_PARIDADE_EN
            r_par_err     <= 1'b0;
`endif
        end else begin
            // Pulse outputs are high for exactly one cycle.
            r_dado_valido <= 1'b0;
            r_erro        <= 1'b0;
            r_cmd_match   <= 1'b0;

            case (r_estado)
                ST_IDLE: begin
                    r_timer   <= 16'd0;
                    r_bit_cnt <= 3'd0;
                    if (!w_rx) begin
                        r_estado <= ST_START;
                    end
                end

                ST_START: begin
                    if (w_half_tick) begin
                        r_timer <= 16'd0;
                        // Line back high at mid start bit: a glitch, not a frame.
                        r_estado <= w_rx ? ST_IDLE : ST_DATA;
                    end else begin
                        r_timer <= r_timer + 16'd1;
                    end
                end

                ST_DATA: begin
                    if (w_bit_tick) begin
                        r_timer   <= 16'd0;
                        r_shift   <= {w_rx, r_shift[7:1]};  // LSB arrives first
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
`ifdef RECEPTOR_PARIDADE_EN
                            r_estado <= ST_PARIDADE;
`else
                            r_estado <= ST_STOP;
`endif
                        end
                    end else begin
                        r_timer <= r_timer + 16'd1;
                    end
                end

`ifdef RECEPTOR_PARIDADE_EN
                ST_PARIDADE: begin
                    if (w_bit_tick) begin
                        r_timer <= 16'd0;
                        // Even parity: data bits plus parity bit must XOR to 0.
                        r_par_err <= w_rx ^ (^r_shift);
                        r_estado  <= ST_STOP;
                    end else begin
                        r_timer <= r_timer + 16'd1;
                    end
                end
`endif

                ST_STOP: begin
                    if (w_bit_tick) begin
                        r_timer  <= 16'd0;
                        r_estado <= ST_IDLE;
                        if (!w_rx) begin
                            r_erro <= 1'b1;
`ifdef RECEPTOR_PARIDADE_EN
                        end else if (r_par_err) begin
                            r_erro <= 1'b1;
`endif
                        end else begin
                            r_dado        <= r_shift;
                            r_dado_valido <= 1'b1;
                            r_cmd_match   <= (r_shift == CMD_PREPARAR);
                        end
                    end else begin
                        r_timer <= r_timer + 16'd1;
                    end
                end

                default: begin
                    r_estado <= ST_IDLE;
                end
            endcase
        end
    end

    // ocupado is looked at in the very cycle the byte is presented, so the
    // brew/ignore decision reflects the cafeteira's current state.
    assign preparar         = r_dado_valido & r_cmd_match & ~ocupado;
    assign comando_ignorado = r_dado_valido & r_cmd_match &  ocupado;
    assign dado_valido      = r_dado_valido;
    assign erro_recepcao    = r_erro;
    assign dado             = r_dado;
    assign db_estado        = {1'b0, r_estado};

endmodule

// File: tb/tb_receptor_comando.sv
// Purpose : self-checking bench for receptor_comando with a frame-level reference model.
// Latency : frames are driven bit by bit; results are collected by a monitor and compared per test.
// Backpr. : none; ocupado is randomised per frame and held steady across it.

module tb_receptor_comando;

    localparam int         CLKS = 16;
    localparam logic [7:0] CMD  = 8'h50;
`ifdef RECEPTOR_PARIDADE_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic       rx_esp;
    logic       ocupado;
    logic       preparar;
    logic [7:0] dado;
    logic       dado_valido;
    logic       erro_recepcao;
    logic       comando_ignorado;
    logic [3:0] db_estado;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic       err;
        logic [7:0] d;
        logic       prep;
        logic       ign;
    } ev_t;

    ev_t        obs_q[$];
    ev_t        exp_q[$];
    logic [7:0] last_dado;

    receptor_comando #(
        .CLKS_PER_BIT (CLKS),
        .CMD_PREPARAR (CMD)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .rx_esp           (rx_esp),
        .ocupado          (ocupado),
        .preparar         (preparar),
        .dado             (dado),
        .dado_valido      (dado_valido),
        .erro_recepcao    (erro_recepcao),
        .comando_ignorado (comando_ignorado),
        .db_estado        (db_estado)
    );

    always #5 clock = ~clock;

    // Monitor: records every output event and checks the pulse invariants.
    always @(negedge clock) begin
        if (dado_valido) obs_q.push_back('{1'b0, dado, preparar, comando_ignorado});
        if (erro_recepcao) obs_q.push_back('{1'b1, dado, preparar, comando_ignorado});
        if (preparar || comando_ignorado) begin
            checks++;
            if ((preparar && comando_ignorado) || !dado_valido) begin
                failures++;
                $display("FAIL invariant: preparar=%0b ignorado=%0b dado_valido=%0b, required exclusive and with dado_valido",
                         preparar, comando_ignorado, dado_valido);
            end
        end
    end

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic drive_bit(input logic v);
        rx_esp = v;
        repeat (CLKS) @(posedge clock);
        #1;
    endtask

    task automatic line_idle(input int bits);
        rx_esp = 1'b1;
        repeat (bits * CLKS) @(posedge clock);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit par_ok);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        if (PAR_EN) drive_bit((^b) ^ ~par_ok);
        drive_bit(stop_ok);
    endtask

    // Reference model: outcome of one frame from the framing rules.
    task automatic model_frame(input logic [7:0] b, input bit stop_ok, input bit par_ok, input bit ocp);
        if (!stop_ok || (PAR_EN && !par_ok)) begin
            exp_q.push_back('{1'b1, last_dado, 1'b0, 1'b0});
        end else begin
            exp_q.push_back('{1'b0, b, (b == CMD) && !ocp, (b == CMD) && ocp});
            last_dado = b;
        end
    endtask

    task automatic clear_queues();
        obs_q.delete();
        exp_q.delete();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0; rx_esp = 1'b1; ocupado = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if ({preparar, dado_valido, erro_recepcao, comando_ignorado} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_pulses: got %b required 0000", {preparar, dado_valido, erro_recepcao, comando_ignorado});
        end
        checks++;
        if (dado !== 8'h00) begin failures++; $display("FAIL reset_dado: got %h required 00", dado); end
        checks++;
        if (db_estado !== 4'd0) begin failures++; $display("FAIL reset_state: got %0d required 0", db_estado); end
        reset = 1'b1;
        last_dado = 8'h00;
        line_idle(1);
    endtask

    task automatic test_comando(input bit ocp, input string nm);
        ev_t e;
        clear_queues();
        ocupado = ocp;
        send_frame(CMD, 1'b1, 1'b1);
        line_idle(2);
        last_dado = CMD;
        e = '{1'b0, CMD, !ocp, ocp};
        checks++;
        if (obs_q.size() !== 1) begin
            failures++; $display("FAIL %s_count: got %0d events required 1", nm, obs_q.size());
        end else begin
            checks++;
            if (obs_q[0] !== e) begin
                failures++; $display("FAIL %s_event: got %h required %h", nm, obs_q[0], e);
            end
        end
        ocupado = 1'b0;
    endtask

    task automatic test_stop_error();
        logic [7:0] prev;
        clear_queues();
        prev = last_dado;
        send_frame(8'hA5, 1'b0, 1'b1);
        line_idle(2);
        checks++;
        if (obs_q.size() !== 1 || obs_q[0] !== ev_t'({1'b1, prev, 1'b0, 1'b0})) begin
            failures++; $display("FAIL stop_error: got %0d events first=%h required 1 event %h",
                                 obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : ev_t'(0), ev_t'({1'b1, prev, 2'b00}));
        end
        clear_queues();
        send_frame(8'h3C, 1'b1, 1'b1);
        line_idle(2);
        last_dado = 8'h3C;
        checks++;
        if (obs_q.size() !== 1 || obs_q[0] !== ev_t'({1'b0, 8'h3C, 1'b0, 1'b0})) begin
            failures++; $display("FAIL after_error_3C: got %0d events dado=%h required 1 event dado=3c", obs_q.size(), dado);
        end
    endtask

    task automatic test_glitch();
        clear_queues();
        rx_esp = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        line_idle(2);
        checks++;
        if (obs_q.size() !== 0) begin failures++; $display("FAIL glitch_pulse: got %0d events required 0", obs_q.size()); end
        checks++;
        if (db_estado !== 4'd0) begin failures++; $display("FAIL glitch_state: got %0d required 0", db_estado); end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] b;
        b = 8'hA5;
        clear_queues();
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(b[i]);
        rx_esp = b[3];
        repeat (CLKS / 2) @(posedge clock);
        #1;
        checks++;
        if (db_estado !== 4'd2) begin failures++; $display("FAIL midframe_in_data: got %0d required 2", db_estado); end
        reset = 1'b0;
        #1;
        checks++;
        if (db_estado !== 4'd0 || dado !== 8'h00) begin
            failures++; $display("FAIL midframe_reset: state=%0d dado=%h required 0 / 00", db_estado, dado);
        end
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        last_dado = 8'h00;
        line_idle(2);
        checks++;
        if (obs_q.size() !== 0) begin failures++; $display("FAIL midframe_pulse: got %0d events required 0", obs_q.size()); end
        clear_queues();
        send_frame(8'hC3, 1'b1, 1'b1);
        line_idle(2);
        last_dado = 8'hC3;
        checks++;
        if (obs_q.size() !== 1 || dado !== 8'hC3) begin
            failures++; $display("FAIL resume_after_reset: got %0d events dado=%h required 1 event dado=c3", obs_q.size(), dado);
        end
    endtask

    task automatic test_random(input int n);
        logic [7:0] b;
        bit         s_ok, p_ok, ocp;
        clear_queues();
        for (int k = 0; k < n; k++) begin
            b    = ($urandom_range(0, 3) == 0) ? CMD : 8'($urandom);
            s_ok = ($urandom_range(0, 4) != 0);
            p_ok = PAR_EN ? ($urandom_range(0, 4) != 0) : 1'b1;
            ocp  = 1'($urandom);
            ocupado = ocp;
            model_frame(b, s_ok, p_ok, ocp);
            send_frame(b, s_ok, p_ok);
            line_idle(2);
        end
        ocupado = 1'b0;
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            failures++; $display("FAIL random_count: got %0d events required %0d", obs_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    failures++; $display("FAIL random_event[%0d]: got %h required %h", i, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] frames [4];
        frames[0] = 8'h12; frames[1] = CMD; frames[2] = 8'hFF; frames[3] = 8'h00;
        clear_queues();
        ocupado = 1'b0;
        for (int k = 0; k < 4; k++) begin
            model_frame(frames[k], 1'b1, 1'b1, 1'b0);
            send_frame(frames[k], 1'b1, 1'b1);
        end
        line_idle(2);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            failures++; $display("FAIL b2b_count: got %0d events required %0d", obs_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    failures++; $display("FAIL b2b_event[%0d]: got %h required %h", i, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

`ifdef RECEPTOR_PARIDADE_EN
    task automatic test_paridade();
        logic [7:0] prev;
        prev = last_dado;
        clear_queues();
        ocupado = 1'b0;
        send_frame(CMD, 1'b1, 1'b0);
        line_idle(2);
        checks++;
        if (obs_q.size() !== 1 || obs_q[0] !== ev_t'({1'b1, prev, 1'b0, 1'b0})) begin
            failures++; $display("FAIL parity_bad: got %0d events dado=%h required 1 error event dado=%h", obs_q.size(), dado, prev);
        end
        clear_queues();
        send_frame(CMD, 1'b1, 1'b1);
        line_idle(2);
        last_dado = CMD;
        checks++;
        if (obs_q.size() !== 1 || obs_q[0] !== ev_t'({1'b0, CMD, 1'b1, 1'b0})) begin
            failures++; $display("FAIL parity_good: got %0d events required 1 preparar event", obs_q.size());
        end
    endtask
`endif

    initial begin
        test_reset();
        test_comando(1'b0, "cmd_free");
        test_comando(1'b1, "cmd_busy");
        test_stop_error();
        test_glitch();
        test_reset_mid_frame();
        test_random(20);
        test_back_to_back();
`ifdef RECEPTOR_PARIDADE_EN
        test_paridade();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
